// File: rtl/mul_issue_hilo.sv
// Issue/retire stage around the sequential 32x32 multiplier: one multiply in
// flight at a time, product committed into architectural HI/LO on done.
module mul_issue_hilo #(
    parameter int TIMEOUT_CYCLES = 48,
    parameter int CNT_W          = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_a,
    input  logic [31:0] i_req_b,
    input  logic        i_flush,
    input  logic        i_wr_hi,
    input  logic        i_wr_lo,
    input  logic [31:0] i_wr_data,
    output logic        o_mul_start,
    output logic        o_mul_is_signed,
    output logic [31:0] o_mul_op_a,
    output logic [31:0] o_mul_op_b,
    input  logic        i_mul_busy,
    input  logic        i_mul_done,
    input  logic [63:0] i_mul_product,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_hilo_valid,
    output logic        o_res_done,
    output logic        o_timeout
);

    // state  | meaning
    // IDLE   | HI/LO valid, request and mthi/mtlo accepted
    // LAUNCH | start pulse to the multiplier (suppressed by flush)
    // WAIT   | multiplier running, product commits on done
    // DRAIN  | flushed, waiting for done to discard the product
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT_CYCLES);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic             r_is_signed;
    logic             r_res_done;
    logic             w_accept;
    logic             w_running;
    logic             w_expired;
    logic             w_commit;

    assign w_accept  = (r_state == S_IDLE) && i_req_valid && !i_flush;
    assign w_running = (r_state == S_WAIT) || (r_state == S_DRAIN);
    // done on the expiry cycle still counts as a normal completion
    assign w_expired = w_running && (r_cnt == TC) && !i_mul_done;
    assign w_commit  = (r_state == S_WAIT) && i_mul_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_next = i_flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (i_mul_done || w_expired) begin
                    w_next = S_IDLE;
                end else if (i_flush) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_mul_done || w_expired) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready  = 1'b0;
        o_hilo_valid = 1'b1;
        o_mul_start  = 1'b0;
        o_timeout    = 1'b0;
        if (!reset) begin
            o_req_ready  = (r_state == S_IDLE);
            o_hilo_valid = (r_state == S_IDLE);
            o_mul_start  = (r_state == S_LAUNCH) && !i_flush;
            o_timeout    = w_expired;
        end
    end

    assign o_res_done = r_res_done && !reset;

    // cleared during LAUNCH so the first WAIT cycle reads zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_cnt <= '0;
        end else if (w_running) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi        <= '0;
            r_lo        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_is_signed <= 1'b0;
            r_res_done  <= 1'b0;
        end else begin
            r_res_done <= w_commit;
            if (w_accept) begin
                r_op_a      <= i_req_a;
                r_op_b      <= i_req_b;
                r_is_signed <= i_req_signed;
            end
            if (w_commit) begin
                r_hi <= i_mul_product[63:32];
                r_lo <= i_mul_product[31:0];
            end else if (r_state == S_IDLE) begin
                if (i_wr_hi) begin
                    r_hi <= i_wr_data;
                end
                if (i_wr_lo) begin
                    r_lo <= i_wr_data;
                end
            end
        end
    end

    assign o_hi            = r_hi;
    assign o_lo            = r_lo;
    assign o_mul_op_a      = r_op_a;
    assign o_mul_op_b      = r_op_b;
    assign o_mul_is_signed = r_is_signed;

    // a stale busy in LAUNCH is tolerated; start is issued regardless
    cover property (@(posedge clk) disable iff (reset) (r_state == S_LAUNCH) && i_mul_busy);

endmodule

// File: tb/tb_mul_issue_hilo.sv
// Bench for mul_issue_hilo: behavioural multiplier stub plus an outcome model
// derived from request timing (accept, flush cycle, multiplier latency).
module tb_mul_issue_hilo;

    localparam int MUL_LAT = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_signed;
    logic [31:0] i_req_a;
    logic [31:0] i_req_b;
    logic        i_flush;
    logic        i_wr_hi;
    logic        i_wr_lo;
    logic [31:0] i_wr_data;
    logic        o_mul_start;
    logic        o_mul_is_signed;
    logic [31:0] o_mul_op_a;
    logic [31:0] o_mul_op_b;
    logic        i_mul_busy;
    logic        i_mul_done;
    logic [63:0] i_mul_product;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_hilo_valid;
    logic        o_res_done;
    logic        o_timeout;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    bit          stub = 1'b0;
    bit          force_busy = 1'b0;
    bit          noise = 1'b0;

    mul_issue_hilo #(.TIMEOUT_CYCLES(48), .CNT_W(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_signed   (i_req_signed),
        .i_req_a        (i_req_a),
        .i_req_b        (i_req_b),
        .i_flush        (i_flush),
        .i_wr_hi        (i_wr_hi),
        .i_wr_lo        (i_wr_lo),
        .i_wr_data      (i_wr_data),
        .o_mul_start    (o_mul_start),
        .o_mul_is_signed(o_mul_is_signed),
        .o_mul_op_a     (o_mul_op_a),
        .o_mul_op_b     (o_mul_op_b),
        .i_mul_busy     (i_mul_busy),
        .i_mul_done     (i_mul_done),
        .i_mul_product  (i_mul_product),
        .o_hi           (o_hi),
        .o_lo           (o_lo),
        .o_hilo_valid   (o_hilo_valid),
        .o_res_done     (o_res_done),
        .o_timeout      (o_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        return 64'(sa * sb);
    endfunction

    // Multiplier stand-in: done MUL_LAT cycles after the start pulse.
    int          m_cnt = 0;
    logic [63:0] m_prod = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic        m_s = 1'b0;
    int          n_starts = 0;
    int          n_restart = 0;
    int          n_op_moved = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt <= 0;
        end else if (o_mul_start) begin
            n_starts <= n_starts + 1;
            if (m_cnt != 0) n_restart <= n_restart + 1;
            m_a <= o_mul_op_a;
            m_b <= o_mul_op_b;
            m_s <= o_mul_is_signed;
            if (!stub) begin
                m_cnt  <= MUL_LAT;
                m_prod <= ref_mul(o_mul_op_a, o_mul_op_b, o_mul_is_signed);
            end
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (o_mul_op_a !== m_a || o_mul_op_b !== m_b || o_mul_is_signed !== m_s)
                n_op_moved <= n_op_moved + 1;
        end
    end

    assign i_mul_busy    = (m_cnt != 0) || force_busy;
    assign i_mul_done    = (m_cnt == 1);
    assign i_mul_product = i_mul_done ? m_prod : 64'h0BAD_0BAD_0BAD_0BAD;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_write(input logic wh, input logic wl, input logic [31:0] wd);
        chk("wr_in_idle", 64'(o_req_ready), 64'd1);
        i_wr_hi = wh; i_wr_lo = wl; i_wr_data = wd;
        tick;
        i_wr_hi = 1'b0; i_wr_lo = 1'b0;
        if (wh) exp_hi = wd;
        if (wl) exp_lo = wd;
        chk("wr_hi_val", 64'(o_hi), 64'(exp_hi));
        chk("wr_lo_val", 64'(o_lo), 64'(exp_lo));
    endtask

    // flush_at: cycle (0 = accept cycle) at which flush is held for one cycle; -1 none
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int flush_at, input logic wh, input logic wl,
                          input logic [31:0] wd);
        logic [63:0] p;
        bit dropped, cancelled, drained, commit;
        int exp_ready, t, start_cyc, done_cyc, ready_cyc, bad_valid, tmo;
        p         = ref_mul(a, b, s);
        dropped   = (flush_at == 0);
        cancelled = (flush_at == 1);
        drained   = (flush_at >= 2 && flush_at <= MUL_LAT);
        commit    = !dropped && !cancelled && !drained;
        exp_ready = dropped ? 1 : (cancelled ? 2 : MUL_LAT + 2);
        if (wh) exp_hi = wd;
        if (wl) exp_lo = wd;
        chk("ready_at_issue", 64'(o_req_ready), 64'd1);
        i_req_valid = 1'b1; i_req_a = a; i_req_b = b; i_req_signed = s;
        i_flush = dropped; i_wr_hi = wh; i_wr_lo = wl; i_wr_data = wd;
        t = 0; start_cyc = -1; done_cyc = -1; ready_cyc = -1; bad_valid = 0; tmo = 0;
        while (ready_cyc < 0 && t < 120) begin
            tick;
            t++;
            i_req_valid = 1'b0;
            i_flush = (t == flush_at);
            if (noise && t < exp_ready) begin
                i_wr_hi = 1'($urandom_range(0, 1));
                i_wr_lo = 1'($urandom_range(0, 1));
                i_wr_data = $urandom;
            end else begin
                i_wr_hi = 1'b0; i_wr_lo = 1'b0;
            end
            #1;
            if (o_mul_start) start_cyc = (start_cyc < 0) ? t : -2;
            if (o_res_done) done_cyc = t;
            if (o_timeout) tmo++;
            if (o_hilo_valid !== (t >= exp_ready)) bad_valid++;
            if (o_req_ready) ready_cyc = t;
        end
        i_flush = 1'b0; i_wr_hi = 1'b0; i_wr_lo = 1'b0;
        chk("ready_cycle", 64'(ready_cyc), 64'(exp_ready));
        chk("start_cycle", 64'(start_cyc), 64'((dropped || cancelled) ? -1 : 1));
        chk("res_done_cycle", 64'(done_cyc), 64'(commit ? MUL_LAT + 2 : -1));
        chk("hilo_valid_interlock", 64'(bad_valid), 64'd0);
        chk("no_timeout", 64'(tmo), 64'd0);
        if (commit) {exp_hi, exp_lo} = p;
        chk("hi", 64'(o_hi), 64'(exp_hi));
        chk("lo", 64'(o_lo), 64'(exp_lo));
        if (!dropped) begin
            chk("op_a_held", 64'(o_mul_op_a), 64'(a));
            chk("op_b_held", 64'(o_mul_op_b), 64'(b));
            chk("op_signed_held", 64'(o_mul_is_signed), 64'(s));
        end
    endtask

    task automatic run_timeout(input int flush_at);
        int t, to_cyc, bad;
        stub = 1'b1;
        chk("to_ready_at_issue", 64'(o_req_ready), 64'd1);
        i_req_valid = 1'b1; i_req_a = $urandom; i_req_b = $urandom; i_req_signed = 1'b0;
        t = 0; to_cyc = -1; bad = 0;
        while (to_cyc < 0 && t < 200) begin
            tick;
            t++;
            i_req_valid = 1'b0;
            i_flush = (t == flush_at);
            #1;
            if (o_res_done || o_hilo_valid || o_req_ready) bad++;
            if (o_timeout) to_cyc = t;
        end
        i_flush = 1'b0;
        // accept at 0, LAUNCH at 1, WAIT entered at 2, expiry 48 cycles later
        chk("timeout_cycle", 64'(to_cyc), 64'd50);
        chk("timeout_quiet_before", 64'(bad), 64'd0);
        tick;
        chk("timeout_ready_after", 64'(o_req_ready), 64'd1);
        chk("timeout_hilo_valid", 64'(o_hilo_valid), 64'd1);
        chk("timeout_one_cycle", 64'(o_timeout), 64'd0);
        chk("timeout_hi_kept", 64'(o_hi), 64'(exp_hi));
        chk("timeout_lo_kept", 64'(o_lo), 64'(exp_lo));
        stub = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int bad, fa;
        reset = 1'b1; i_req_valid = 1'b0; i_req_signed = 1'b0; i_req_a = '0; i_req_b = '0;
        i_flush = 1'b0; i_wr_hi = 1'b0; i_wr_lo = 1'b0; i_wr_data = '0;
        exp_hi = '0; exp_lo = '0;
        tick; tick;
        chk("rst_ready_low", 64'(o_req_ready), 64'd0);
        chk("rst_hilo_valid", 64'(o_hilo_valid), 64'd1);
        chk("rst_start", 64'(o_mul_start), 64'd0);
        chk("rst_res_done", 64'(o_res_done), 64'd0);
        chk("rst_timeout", 64'(o_timeout), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready_after", 64'(o_req_ready), 64'd1);
        chk("rst_hi", 64'(o_hi), 64'd0);
        chk("rst_lo", 64'(o_lo), 64'd0);
        chk("rst_op_a", 64'(o_mul_op_a), 64'd0);
        chk("rst_op_signed", 64'(o_mul_is_signed), 64'd0);

        run_op(32'd7, 32'hFFFF_FFFD, 1'b1, -1, 1'b0, 1'b0, '0);
        tick;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 1'b0, 1'b0, '0);
        run_op(32'd3, 32'd5, 1'b0, -1, 1'b0, 1'b0, '0);
        tick;

        do_write(1'b1, 1'b1, 32'hA5A5_A5A5);
        noise = 1'b1;
        run_op(32'd2, 32'd2, 1'b0, 11, 1'b0, 1'b0, '0);
        noise = 1'b0;
        tick;
        run_op(32'd9, 32'd9, 1'b1, 1, 1'b0, 1'b0, '0);
        run_op(32'd4, 32'd4, 1'b0, 0, 1'b1, 1'b0, 32'h1111_2222);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 35, 1'b1, 1'b1, 32'h3333_4444);
        force_busy = 1'b1;
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0, -1, 1'b0, 1'b0, '0);
        force_busy = 1'b0;
        tick;

        run_timeout(-1);
        run_timeout(10);

        do_write(1'b1, 1'b1, 32'h1234_5678);
        i_req_valid = 1'b1; i_req_a = 32'd9; i_req_b = 32'd9; i_req_signed = 1'b0;
        tick;
        i_req_valid = 1'b0;
        repeat (6) tick;
        reset = 1'b1;
        #1;
        chk("rstw_hilo_valid", 64'(o_hilo_valid), 64'd1);
        chk("rstw_ready_low", 64'(o_req_ready), 64'd0);
        tick;
        exp_hi = '0; exp_lo = '0;
        chk("rstw_hi", 64'(o_hi), 64'd0);
        chk("rstw_lo", 64'(o_lo), 64'd0);
        chk("rstw_op_a", 64'(o_mul_op_a), 64'd0);
        reset = 1'b0;
        #1;
        chk("rstw_ready_after", 64'(o_req_ready), 64'd1);
        bad = 0;
        repeat (45) begin
            tick;
            if (o_res_done || o_mul_start || o_timeout || !o_hilo_valid) bad++;
        end
        chk("rstw_quiet", 64'(bad), 64'd0);

        noise = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0)
                do_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            fa = ($urandom_range(0, 9) < 7) ? -1 : int'($urandom_range(0, 35));
            run_op(pick32(), pick32(), 1'($urandom_range(0, 1)), fa,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            repeat ($urandom_range(0, 2)) tick;
        end
        noise = 1'b0;

        chk("no_restart_while_busy", 64'(n_restart), 64'd0);
        chk("operands_stable_in_flight", 64'(n_op_moved), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
